// File: rtl/bit_reverse_unload.sv
// Reorder buffer for the NTT inverse side. It takes one bit-reversed polynomial
// (32 beats x 32 lanes) and replays it in natural order, 32 coefficients per beat.
module bit_reverse_unload #(
  parameter int DATA_SIZE_ARB = 16,
  parameter int PE_NUMBER     = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_SIZE_ARB*PE_NUMBER-1:0] data_in,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_SIZE_ARB*PE_NUMBER-1:0] data_out,
  output logic                               out_last,
  output logic                               busy
);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t                   state;
  logic [4:0]               wr_cnt;
  logic [4:0]               rd_cnt;
  logic [DATA_SIZE_ARB-1:0] mem [PE_NUMBER][PE_NUMBER];

  logic in_accept;
  logic out_accept;

  function automatic logic [4:0] rev5(input logic [4:0] x);
    logic [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = x[4-i];
    return r;
  endfunction

  assign in_accept  = in_valid && in_ready;
  assign out_accept = out_valid && out_ready;

  // The handshake outputs are held in flops and updated together with the state,
  // so every output comes straight from a register.
  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples values from before the edge, whatever order the statements run in.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FILL;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (in_accept) begin
            wr_cnt <= wr_cnt + 5'd1;
            busy   <= 1'b1;
            if (wr_cnt == 5'd31) begin
              state     <= DRAIN;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_accept) begin
            rd_cnt   <= rd_cnt + 5'd1;
            out_last <= (rd_cnt == 5'd30);
            if (rd_cnt == 5'd31) begin
              state     <= FILL;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              busy      <= 1'b0;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // NOTE: the coefficient array has no reset. A reset only discards the
  // counters, and the stale words get overwritten before anyone reads them.
  always_ff @(posedge clk) begin
    if (!reset && in_accept) begin
      for (int k = 0; k < PE_NUMBER; k++)
        mem[wr_cnt][k] <= data_in[DATA_SIZE_ARB*k +: DATA_SIZE_ARB];
    end
  end

  // Output beat m, lane j holds the word written at beat rev5(j), lane rev5(m).
  // NOTE: data_out gets a default before the loop, so this block cannot infer a latch.
  always_comb begin
    data_out = '0;
    for (int j = 0; j < PE_NUMBER; j++)
      data_out[DATA_SIZE_ARB*j +: DATA_SIZE_ARB] = mem[rev5(5'(j))][rev5(rd_cnt)];
  end

endmodule
